// File: rtl/pp_merge.sv
// Ping-pong merge of two AXI-Stream paths into one framed output with per-frame trailer.
// Defining PP_MERGE_STATS_EN adds a wrapping 16-bit count of completed frames.
`timescale 1ns/1ps

module pp_merge_fifo #(
  parameter int DW    = 128,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          empty,
  output logic          full
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          do_wr, do_rd;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // A full FIFO may still accept a write when its head leaves in the same cycle.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; equal pointers already mark every entry as invalid.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end
endmodule

module pp_merge #(
  parameter int DW          = 128,
  parameter int PP_GROUP    = 2,
  parameter int PACKET_SIZE = 2,
  parameter int FRAME_SIZE  = 256,
  parameter int TRAIL_LEN   = 6,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] axis_in1_tdata,
  input  logic          axis_in1_tvalid,
  output logic          axis_in1_tready,
  input  logic [DW-1:0] axis_in2_tdata,
  input  logic          axis_in2_tvalid,
  output logic          axis_in2_tready,
  output logic [DW-1:0] axis_out_tdata,
  output logic          axis_out_tvalid,
  input  logic          axis_out_tready,
  output logic          axis_out_tlast,
  output logic [1:0]    overflow,
  output logic [15:0]   frame_count
);
  typedef enum logic [1:0] {S_DATA1, S_DATA2, S_TRAIL} state_e;

  localparam logic [15:0] GRP_LAST = 16'(PP_GROUP * PACKET_SIZE - 1);
  localparam logic [15:0] FRM_LAST = 16'(FRAME_SIZE - 1);
  localparam logic [15:0] TRL_LAST = 16'(TRAIL_LEN - 1);
  localparam logic [15:0] TRL_DONE = 16'(TRAIL_LEN);

  logic [DW-1:0] head1, head2;
  logic          empty1, empty2, full1, full2;
  logic          pop1, pop2;

  state_e        state_q, state_d;
  logic [15:0]   grp_cnt_q, grp_cnt_d;
  logic [15:0]   frm_cnt_q, frm_cnt_d;
  logic [15:0]   fwd_cnt_q, fwd_cnt_d;
  logic [15:0]   drp_cnt_q, drp_cnt_d;
  logic [1:0]    overflow_q, overflow_d;

  logic          out_valid, out_last, data_pop;
  logic [DW-1:0] out_data;

  assign axis_in1_tready = !full1;
  assign axis_in2_tready = !full2;

  pp_merge_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (axis_in1_tvalid && !full1),
    .wr_data (axis_in1_tdata),
    .rd_en   (pop1),
    .rd_data (head1),
    .empty   (empty1),
    .full    (full1)
  );

  pp_merge_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo2 (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (axis_in2_tvalid && !full2),
    .wr_data (axis_in2_tdata),
    .rd_en   (pop2),
    .rd_data (head2),
    .empty   (empty2),
    .full    (full2)
  );

  always_comb begin
    overflow_d = overflow_q | {axis_in2_tvalid && full2, axis_in1_tvalid && full1};
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    grp_cnt_d = grp_cnt_q;
    frm_cnt_d = frm_cnt_q;
    fwd_cnt_d = fwd_cnt_q;
    drp_cnt_d = drp_cnt_q;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = head1;
    pop1      = 1'b0;
    pop2      = 1'b0;
    data_pop  = 1'b0;

    case (state_q)
      S_DATA1: begin
        out_valid = !empty1;
        pop1      = out_valid && axis_out_tready;
        data_pop  = pop1;
      end
      S_DATA2: begin
        out_valid = !empty2;
        out_data  = head2;
        pop2      = out_valid && axis_out_tready;
        data_pop  = pop2;
      end
      S_TRAIL: begin
        // Path 1 trailer goes downstream; path 2 trailer drains regardless of tready.
        out_valid = !empty1 && (fwd_cnt_q != TRL_DONE);
        out_last  = out_valid && (fwd_cnt_q == TRL_LAST);
        pop1      = out_valid && axis_out_tready;
        pop2      = !empty2 && (drp_cnt_q != TRL_DONE);
        if (pop1) fwd_cnt_d = fwd_cnt_q + 16'd1;
        if (pop2) drp_cnt_d = drp_cnt_q + 16'd1;
        if ((fwd_cnt_q == TRL_DONE) && (drp_cnt_q == TRL_DONE)) begin
          state_d   = S_DATA1;
          fwd_cnt_d = '0;
          drp_cnt_d = '0;
        end
      end
      default: state_d = S_DATA1;
    endcase

    // End of frame outranks the group toggle.
    if (data_pop) begin
      if (frm_cnt_q == FRM_LAST) begin
        frm_cnt_d = '0;
        grp_cnt_d = '0;
        state_d   = S_TRAIL;
      end else begin
        frm_cnt_d = frm_cnt_q + 16'd1;
        if (grp_cnt_q == GRP_LAST) begin
          grp_cnt_d = '0;
          state_d   = (state_q == S_DATA1) ? S_DATA2 : S_DATA1;
        end else begin
          grp_cnt_d = grp_cnt_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_DATA1;
      grp_cnt_q  <= '0;
      frm_cnt_q  <= '0;
      fwd_cnt_q  <= '0;
      drp_cnt_q  <= '0;
      overflow_q <= '0;
    end else begin
      state_q    <= state_d;
      grp_cnt_q  <= grp_cnt_d;
      frm_cnt_q  <= frm_cnt_d;
      fwd_cnt_q  <= fwd_cnt_d;
      drp_cnt_q  <= drp_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign axis_out_tvalid = out_valid;
  assign axis_out_tdata  = out_data;
  assign axis_out_tlast  = out_last;
  assign overflow        = overflow_q;

`ifdef PP_MERGE_STATS_EN
  logic        trail_exit;
  logic [15:0] frame_count_q, frame_count_d;

  assign trail_exit = (state_q == S_TRAIL) && (fwd_cnt_q == TRL_DONE) && (drp_cnt_q == TRL_DONE);

  always_comb begin
    frame_count_d = frame_count_q + {15'd0, trail_exit};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_count_q <= '0;
    else       frame_count_q <= frame_count_d;
  end

  assign frame_count = frame_count_q;
`else
  assign frame_count = '0;
`endif
endmodule

// File: doc/pp_merge.md
PP_MERGE -- requirements
Module: pp_merge

Interface
REQ-001 Parameters SHALL be:
- DW, 128, beat width.
- PP_GROUP, 2, packets per ping-pong group.
- PACKET_SIZE, 2, beats per packet.
- FRAME_SIZE, 256, data beats per frame; a multiple of 2*PP_GROUP*PACKET_SIZE.
- TRAIL_LEN, 6, trailer beats per path after each frame (metadata plus header).
- FIFO_DEPTH, 8, per-path FIFO entries; a power of 2, at least 2.
REQ-002 The clock and reset SHALL be a single clock `clk` and an asynchronous, active-high reset `reset`.
REQ-003 Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: async active-high reset.
- `axis_in1_tdata` in DW: path-1 beat.
- `axis_in1_tvalid` in 1: path-1 valid.
- `axis_in1_tready` out 1: path-1 ready.
- `axis_in2_tdata` in DW: path-2 beat.
- `axis_in2_tvalid` in 1: path-2 valid.
- `axis_in2_tready` out 1: path-2 ready.
- `axis_out_tdata` out DW: merged beat.
- `axis_out_tvalid` out 1: merged valid.
- `axis_out_tready` in 1: downstream ready.
- `axis_out_tlast` out 1: last beat of a frame.
- `overflow` out 2: sticky overflow flags; bit0 = path 1, bit1 = path 2.
- `frame_count` out 16: completed frames.

Function
REQ-004 Each input SHALL feed its own FIFO of FIFO_DEPTH entries; `axis_inN_tready` = !fullN.
REQ-005 A write to FIFO N SHALL occur when `axis_inN_tvalid` and `axis_inN_tready` are both high.
REQ-006 When `axis_inN_tvalid` is high while FIFO N is full, the beat SHALL be dropped and `overflow[N-1]` SHALL be set until reset.
REQ-007 The output SHALL be first-word-fall-through: a beat written into an empty FIFO at edge k SHALL be presentable on `axis_out` from cycle k+1.
REQ-008 A simultaneous read and write on a full FIFO SHALL be allowed, and occupancy SHALL stay unchanged.
REQ-009 The FSM SHALL have three states: S_DATA1, S_DATA2 and S_TRAIL; the reset state is S_DATA1.
REQ-010 In S_DATA1 and S_DATA2, `axis_out_tvalid` SHALL be !empty of the selected FIFO (FIFO1 or FIFO2 respectively), and `axis_out_tdata` SHALL be that FIFO's head.
REQ-011 A beat SHALL pop only when `axis_out_tvalid` and `axis_out_tready` are both high.
REQ-012 A 16-bit `grp_cnt` SHALL count popped beats. At `grp_cnt` = PP_GROUP*PACKET_SIZE-1 on a pop, `grp_cnt` SHALL clear and the state SHALL toggle between S_DATA1 and S_DATA2.
REQ-013 A 16-bit `frm_cnt` SHALL count popped data beats. At `frm_cnt` = FRAME_SIZE-1 on a pop, `frm_cnt` and `grp_cnt` SHALL clear and the state SHALL become S_TRAIL, regardless of the group toggle.
REQ-014 In S_TRAIL, FIFO1 beats SHALL be forwarded (`fwd_cnt` 0..TRAIL_LEN-1).
REQ-015 In S_TRAIL, FIFO2 beats SHALL be discarded at one per cycle whenever FIFO2 is non-empty, independent of `axis_out_tready` (`drp_cnt` 0..TRAIL_LEN-1).
REQ-016 `axis_out_tlast` SHALL be high only in S_TRAIL with `fwd_cnt` = TRAIL_LEN-1 and `axis_out_tvalid` high.
REQ-017 Once `fwd_cnt` has reached TRAIL_LEN, no further FIFO1 beats SHALL be forwarded.
REQ-018 Once `drp_cnt` has reached TRAIL_LEN, no further FIFO2 beats SHALL be discarded.
REQ-019 S_TRAIL SHALL exit to S_DATA1 on the cycle when both `fwd_cnt` and `drp_cnt` have reached TRAIL_LEN; both counters SHALL clear on exit.
REQ-020 In S_DATA1 and S_DATA2, the non-selected FIFO SHALL never pop.
REQ-021 `axis_out_tdata` and `axis_out_tlast` SHALL stay stable while `axis_out_tvalid` is high and `axis_out_tready` is low.

Reset
REQ-022 On `reset` high, asynchronously:
- both FIFOs empty, so both `axis_inN_tready` = 1;
- `axis_out_tvalid` = 0 and `axis_out_tlast` = 0;
- `overflow` = 0 and `frame_count` = 0;
- all counters 0 and the state S_DATA1.
REQ-023 Reset asserted mid-frame SHALL abandon the partial frame, and no stale beat SHALL appear after release.
REQ-024 The first pop after release SHALL come from FIFO1.

Configuration
REQ-025 With macro `PP_MERGE_STATS_EN` defined, `frame_count` SHALL increment (wrapping at 16 bits) on each S_TRAIL exit.
REQ-026 Without `PP_MERGE_STATS_EN`, `frame_count` SHALL be constant 0 and no counter logic SHALL be instantiated.

Verification
REQ-027 The bench SHALL use FRAME_SIZE=16, PP_GROUP=2, PACKET_SIZE=2, TRAIL_LEN=6 and FIFO_DEPTH=8, and SHALL cover these scenarios:
- Basic merge: in1 carries 0x10.. and in2 carries 0x20.., 4 beats per path, alternating, `axis_out_tready`=1 -> output order 10,11,12,13,20,21,22,23,14...; 16 data beats in all.
- Trailer: after a frame, in1 sends A0..A5 and in2 sends B0..B5 -> out carries A0..A5, `axis_out_tlast` is high only on A5, and no B beat appears; then state S_DATA1.
- Backpressure: `axis_out_tready` toggles 1/0 -> no beat lost or duplicated; data is held stable while stalled; in2 FIFO fills, `axis_in2_tready` drops to 0 at 8 entries.
- Overflow: `axis_in1_tvalid` held high with `axis_in1_tready`=0 for 3 cycles -> `overflow` = 2'b01 and stays set until reset.
- Reset mid-frame: `reset` pulsed after 7 data beats -> outputs return to reset values; the next frame starts from FIFO1, with `frm_cnt` restarting at 0.
- Stats: three complete frames with `PP_MERGE_STATS_EN` defined -> `frame_count` = 3; built without the macro -> `frame_count` = 0.
